move_path_fifo: RTL and testbench

Parametrised move-path buffer for the maze-solver datapath. The solver pushes moves one per cycle as it finds them, and the block then replays them to the movement controller under a valid/ready handshake. Replay runs in either order: FIFO for the forward route, LIFO for the backtrack route. It replaces the fixed 256-entry, single-order path queue with configurable width and depth, full/empty/count status, overflow detection and a completion pulse.

---
 rtl/maze_pkg.sv | 17 +
 rtl/move_ram.sv | 26 ++
 rtl/move_path_fifo.sv | 134 +++++++++++++
 tb/tb_move_path_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze-solver datapath: move encodings and the
// move-path buffer state machine encoding.
package maze_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } move_t;

  typedef enum logic {
    LOAD   = 1'b0,
    REPLAY = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/move_ram.sv
// DEPTH x MOVE_W register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module move_ram #(
  parameter int MOVE_W = 2,
  parameter int DEPTH  = 256,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [MOVE_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [MOVE_W-1:0] rdata
);

  logic [MOVE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/move_path_fifo.sv
// Move-path buffer: loads moves from the solver, then replays them FIFO or
// LIFO to the movement controller.
//
// Handshakes: a transfer fires on a cycle where valid and ready are both
// high at the rising edge; valid never depends on ready on the same side.
module move_path_fifo
  import maze_pkg::*;
#(
  parameter int MOVE_W = 2,
  parameter int DEPTH  = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push_valid,
  input  logic [MOVE_W-1:0] push_move,
  output logic              push_ready,
  input  logic              mode,
  input  logic              run,
  input  logic              pop_ready,
  output logic              cur_valid,
  output logic [MOVE_W-1:0] cur_move,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              replay_done,
  output fifo_state_t       dbg_state
);

  localparam int PW = $clog2(DEPTH);

  fifo_state_t       state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;

  logic              push_fire, pop_fire;
  logic [PW-1:0]     rd_addr;
  logic [MOVE_W-1:0] rd_data;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = (state_q == LOAD) && !full;
  assign cur_valid  = (state_q == REPLAY) && run && !empty;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = cur_valid && pop_ready;

  // LIFO reads the newest entry, one below the write pointer (wraps at 0).
  assign rd_addr  = mode_q ? (wr_ptr_q - PW'(1)) : rd_ptr_q;
  assign cur_move = cur_valid ? rd_data : '0;

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign replay_done = done_q;
  assign dbg_state   = state_q;

  move_ram #(
    .MOVE_W (MOVE_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_fire && !clear),
    .waddr (wr_ptr_q),
    .wdata (push_move),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    mode_d     = mode_q;
    if (clear) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (state_q == LOAD) begin
      if (push_fire) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CNT_W'(1);
      end
      if (push_valid && full) begin
        overflow_d = 1'b1;
      end
      if (run && !empty) begin
        state_d = REPLAY;
        mode_d  = mode;
      end
    end else if (pop_fire) begin
      count_d = count_q - CNT_W'(1);
      if (mode_q) begin
        wr_ptr_d = wr_ptr_q - PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (count_q == CNT_W'(1)) begin
        state_d = LOAD;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: tb/tb_move_path_fifo.sv
// Bench for move_path_fifo (DEPTH = 8): directed pushes with hand-written
// expected replay orders, checked by a scoreboard monitor on cur_move.
module tb_move_path_fifo;
  import maze_pkg::*;

  localparam int MOVE_W = 2;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              push_valid;
  logic [MOVE_W-1:0] push_move;
  logic              push_ready;
  logic              mode;
  logic              run;
  logic              pop_ready;
  logic              cur_valid;
  logic [MOVE_W-1:0] cur_move;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              replay_done;
  fifo_state_t       dbg_state;

  logic [MOVE_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  move_path_fifo #(.MOVE_W(MOVE_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push_valid  (push_valid),
    .push_move   (push_move),
    .push_ready  (push_ready),
    .mode        (mode),
    .run         (run),
    .pop_ready   (pop_ready),
    .cur_valid   (cur_valid),
    .cur_move    (cur_move),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .replay_done (replay_done),
    .dbg_state   (dbg_state)
  );

  // Clock / reset infrastructure
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every pop must present the next expected move.
  always @(negedge clk) begin
    if (rst && cur_valid && pop_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(cur_move), 32'hFFFF_FFFF);
      end else begin
        chk("cur_move", 32'(cur_move), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [MOVE_W-1:0] m);
    push_valid = 1'b1;
    push_move  = m;
    tick();
    push_valid = 1'b0;
  endtask

  // Runs a full replay with pop_ready held high and checks the completion pulse.
  task automatic do_replay(input logic m, input string tag);
    int cyc;
    mode = m;
    run = 1'b1;
    pop_ready = 1'b1;
    cyc = 0;
    tick();
    while (exp_q.size() != 0 && cyc < 64) begin
      tick();
      cyc++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    chk({tag, "_done_pulse"}, 32'(replay_done), 1);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_count"}, 32'(count), 0);
    run = 1'b0;
    pop_ready = 1'b0;
    tick();
    chk({tag, "_done_clr"}, 32'(replay_done), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(LOAD));
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    push_valid = 1'b0;
    push_move = '0;
    mode = 1'b0;
    run = 1'b0;
    pop_ready = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_cur_valid", 32'(cur_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_done", 32'(replay_done), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // FIFO replay of 3,1,2
    push(2'd3); push(2'd1); push(2'd2);
    chk("fifo_count3", 32'(count), 3);
    exp_q = '{2'd3, 2'd1, 2'd2};
    do_replay(1'b0, "fifo3");

    // LIFO replay of 3,1,2
    push(2'd3); push(2'd1); push(2'd2);
    exp_q = '{2'd2, 2'd1, 2'd3};
    do_replay(1'b1, "lifo3");

    // Fill to full, then attempt a 9th push
    push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    push(2'd0); push(2'd3); push(2'd2); push(2'd1);
    chk("full_flag", 32'(full), 1);
    chk("full_push_ready", 32'(push_ready), 0);
    chk("full_count", 32'(count), 8);
    chk("full_ovf_before", 32'(overflow), 0);
    push(2'd3);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
    do_replay(1'b0, "fill8");
    chk("ovf_sticky", 32'(overflow), 1);

    // Asynchronous reset in the middle of a replay
    push(2'd0); push(2'd2); push(2'd1);
    exp_q = '{2'd0, 2'd2, 2'd1};
    mode = 1'b0;
    run = 1'b1;
    pop_ready = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cur_valid", 32'(cur_valid), 0);
    chk("arst_cur_move", 32'(cur_move), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_push_ready", 32'(push_ready), 1);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_done", 32'(replay_done), 0);
    exp_q.delete();
    run = 1'b0;
    pop_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Pointer wrap: 6 through, then 5 across the wrap
    push(2'd1); push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd2);
    exp_q = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    do_replay(1'b0, "wrap6");
    push(2'd3); push(2'd2); push(2'd1); push(2'd0); push(2'd3);
    exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    do_replay(1'b0, "wrap5");

    // Flow control: pause after two pops, then hold pop_ready low
    push(2'd0); push(2'd3); push(2'd1);
    exp_q = '{2'd0, 2'd3, 2'd1};
    mode = 1'b0;
    run = 1'b1;
    pop_ready = 1'b1;
    tick();
    tick();
    tick();
    run = 1'b0;
    #1;
    chk("pause_cur_valid", 32'(cur_valid), 0);
    chk("pause_count_a", 32'(count), 1);
    tick();
    tick();
    chk("pause_count_b", 32'(count), 1);
    run = 1'b1;
    pop_ready = 1'b0;
    tick();
    chk("hold_count", 32'(count), 1);
    chk("hold_cur_valid", 32'(cur_valid), 1);
    pop_ready = 1'b1;
    tick();
    chk("flow_left", 32'(exp_q.size()), 0);
    chk("flow_done", 32'(replay_done), 1);
    chk("flow_count", 32'(count), 0);
    exp_q.delete();
    run = 1'b0;
    pop_ready = 1'b0;
    tick();

    // clear coinciding with the final pop suppresses replay_done
    push(2'd2); push(2'd3);
    exp_q = '{2'd3, 2'd2};
    mode = 1'b1;
    run = 1'b1;
    pop_ready = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run = 1'b0;
    pop_ready = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_done", 32'(replay_done), 0);
    chk("clr_state", 32'(dbg_state), 32'(LOAD));
    tick();
    chk("clr_done_next", 32'(replay_done), 0);
    chk("clr_left", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
